// File: rtl/boss_hit_receiver_if.sv
// Hit/health bus between the player weapon logic, the boss draw/FSM side
// and the boss hit receiver.
interface boss_hit_receiver_if;
  logic       frame_tick;
  logic [1:0] game_active;
  logic       melee_hit;
  logic       projectile_hit;
  logic [7:0] boss_hp;
  logic       boss_alive;
  logic       boss_hurt;
  logic       boss_dead;

  modport master (
    output frame_tick, game_active, melee_hit, projectile_hit,
    input  boss_hp, boss_alive, boss_hurt, boss_dead
  );

  modport slave (
    input  frame_tick, game_active, melee_hit, projectile_hit,
    output boss_hp, boss_alive, boss_hurt, boss_dead
  );
endinterface

// File: rtl/boss_hit_receiver.sv
// Boss health tracker: edge-detects weapon hits, applies saturating damage,
// and enforces a frame-counted invulnerability window after each accepted hit.
module boss_hit_receiver #(
  parameter int BOSS_HP   = 200,
  parameter int MELEE_DMG = 4,
  parameter int PROJ_DMG  = 2,
  parameter int IFRAMES   = 8
) (
  input logic              clk,
  input logic              rst,
  boss_hit_receiver_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIGHT  = 2'd1;
  localparam logic [1:0] INVULN = 2'd2;
  localparam logic [1:0] DEAD   = 2'd3;

  localparam logic [7:0] HP_INIT  = 8'(BOSS_HP);
  localparam logic [8:0] MEL_DMG9 = 9'(MELEE_DMG);
  localparam logic [8:0] PRJ_DMG9 = 9'(PROJ_DMG);
  localparam logic [7:0] IFR_INIT = 8'(IFRAMES);

  logic [1:0] state;
  logic [7:0] hp;
  logic [7:0] iframe_cnt;
  logic       melee_q;
  logic       proj_q;
  logic       dead_pulse;

  logic       mel_rise;
  logic       prj_rise;
  logic       fighting;
  logic [8:0] dmg;
  logic [7:0] hp_next;

  always_comb begin
    mel_rise = bus.melee_hit & ~melee_q;
    prj_rise = bus.projectile_hit & ~proj_q;
    fighting = (bus.game_active == 2'd1);
    dmg      = (mel_rise ? MEL_DMG9 : 9'd0) + (prj_rise ? PRJ_DMG9 : 9'd0);
    hp_next  = (dmg >= {1'b0, hp}) ? 8'd0 : (hp - dmg[7:0]);
  end

  // Edge registers track the inputs in every state so a level held through
  // invulnerability or IDLE never produces a late second hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      melee_q <= 1'b0;
      proj_q  <= 1'b0;
    end else begin
      melee_q <= bus.melee_hit;
      proj_q  <= bus.projectile_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hp         <= HP_INIT;
      iframe_cnt <= 8'd0;
      dead_pulse <= 1'b0;
    end else begin
      dead_pulse <= 1'b0;
      if (!fighting) begin
        state      <= IDLE;
        hp         <= HP_INIT;
        iframe_cnt <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            hp    <= HP_INIT;
            state <= FIGHT;
          end
          FIGHT: begin
            if (dmg != 9'd0) begin
              hp <= hp_next;
              if (hp_next == 8'd0) begin
                state      <= DEAD;
                dead_pulse <= 1'b1;
              end else begin
                state      <= INVULN;
                iframe_cnt <= IFR_INIT;
              end
            end
          end
          INVULN: begin
            if (bus.frame_tick) begin
              if (iframe_cnt <= 8'd1) begin
                state      <= FIGHT;
                iframe_cnt <= 8'd0;
              end else begin
                iframe_cnt <= iframe_cnt - 8'd1;
              end
            end
          end
          DEAD: begin
            hp <= 8'd0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.boss_hp    = hp;
  assign bus.boss_alive = (state != DEAD);
  assign bus.boss_hurt  = (state == INVULN);
  assign bus.boss_dead  = dead_pulse;

endmodule
